fft_sample_buff: RTL
====================

FFT_SAMPLE_BUFF -- requirements
Module: fft_sample_buff

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 16, sample width in bits.
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W samples.
- BITREV, 1, 1 = load in bit-reversed address order; 0 = natural order.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the one clock.
- reset, in, 1, reset.
- load_start, in, 1, begin a frame load.
- load_valid, in, 1, load_data is valid.
- load_data, in, DATA_W, streamed frame sample.
- load_ready, out, 1, buffer is accepting load samples.
- load_done, out, 1, one-cycle pulse when the frame is complete.
- rd_en, in, 1, read request.
- rd_addr, in, ADDR_W, read address.
- rd_data, out, DATA_W, read result.
- rd_valid, out, 1, rd_data is valid.
- wr_en, in, 1, write request (butterfly write-back).
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- busy, out, 1, high while in LOAD.
- access_err, out, 1, sticky flag for rd/wr attempted outside RUN.

REQ-003 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-005 IDLE->LOAD SHALL occur on load_start; the load counter SHALL be cleared to 0.
REQ-006 In LOAD, load_ready=1 and busy=1; in every other state both SHALL be 0.
REQ-007 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[bitrev(cnt)] when BITREV=1, or to mem[cnt] when BITREV=0, then increment cnt.
REQ-008 Cycles with load_valid=0 in LOAD SHALL stall: no write, cnt held.
REQ-009 On acceptance of the sample at cnt=DEPTH-1: load_done=1 in the next cycle for exactly one cycle, and the state SHALL become RUN.
REQ-010 load_start in LOAD SHALL restart the load: cnt=0, and a load_valid sample in the same cycle is stored at address 0. No load_done is produced for the aborted frame.
REQ-011 load_start in RUN SHALL move to LOAD with cnt=0; contents are overwritten as the new frame loads.
REQ-012 In RUN, rd_en SHALL have 1-cycle latency: rd_data = mem[rd_addr] and rd_valid=1 in the next cycle. rd_valid=0 otherwise; rd_data holds its last value.
REQ-013 In RUN, wr_en SHALL write wr_data to mem[wr_addr] at the clock edge.
REQ-014 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-015 Simultaneous rd and wr to different addresses SHALL both complete in one cycle.
REQ-016 rd_en or wr_en outside RUN SHALL be ignored: no memory change, rd_valid=0, and access_err set to 1.
REQ-017 access_err SHALL be cleared only by reset or load_start.
REQ-018 bitrev(x) SHALL reverse the ADDR_W bits of x. The counter SHALL be ADDR_W+1 bits wide, or wrap cleanly, so DEPTH-1 is detected without overflow.

Reset
REQ-019 On reset: state=IDLE, cnt=0, load_ready=0, load_done=0, busy=0, rd_valid=0, rd_data=0, access_err=0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Reset SHALL take priority over all inputs in the same cycle, including mid-LOAD, which aborts the load with no load_done.

Verification
REQ-022 ADDR_W=3, BITREV=1: load 0..7 continuously -> mem = {0,4,2,6,1,5,3,7}; load_done pulses once, the cycle after the 8th accept.
REQ-023 ADDR_W=3: load with load_valid deasserted on alternate cycles -> same contents; load_done 1 cycle after the 8th accepted sample; busy high throughout.
REQ-024 RUN: wr_addr=5, wr_data=0xABCD with rd_addr=5 in the same cycle -> rd_data = old value; a second read of address 5 -> 0xABCD, rd_valid high for one cycle each.
REQ-025 IDLE: rd_en=1, addr=2 -> rd_valid=0, access_err=1; it stays 1 until load_start, then reads 0.
REQ-026 Reset asserted after 4 of 8 samples -> IDLE, load_ready=0, no load_done; a following full load completes normally.
REQ-027 BITREV=0: load 0..7 -> mem[i]=i; load_start asserted mid-frame -> counter restarts at 0 with no load_done for the aborted frame.

Source files
------------

// File: rtl/fft_sample_buff.sv
// Frame sample buffer for an in-place FFT: streams one frame in (optionally in
// bit-reversed address order), then serves butterfly reads and write-backs.
module fft_sample_buff #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              access_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_load;
  logic              in_run;
  logic              accept;
  logic              last_accept;
  logic [ADDR_W-1:0] load_idx;
  logic [ADDR_W-1:0] load_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // A restart in LOAD stores its same-cycle sample at index 0, so the index
  // is forced to zero before the optional bit reversal.
  always_comb begin
    in_load     = (state == LOAD);
    in_run      = (state == RUN);
    accept      = in_load && load_valid;
    last_accept = accept && !load_start && (cnt == LAST_CNT);
    load_idx    = load_start ? '0 : cnt[ADDR_W-1:0];
    load_addr   = load_idx;
    if (BITREV != 0) begin
      for (int i = 0; i < ADDR_W; i++) begin
        load_addr[i] = load_idx[ADDR_W-1-i];
      end
    end
    mem_we    = !reset && (accept || (in_run && wr_en));
    mem_waddr = accept ? load_addr : wr_addr;
    mem_wdata = accept ? load_data : wr_data;
  end

  assign load_ready = in_load;
  assign busy       = in_load;

  // Storage is deliberately left out of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      load_done  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      access_err <= 1'b0;
    end else begin
      load_done <= last_accept;
      rd_valid  <= in_run && rd_en;
      if (in_run && rd_en) begin
        rd_data <= mem[rd_addr];
      end
      if (load_start) begin
        access_err <= 1'b0;
      end else if (!in_run && (rd_en || wr_en)) begin
        access_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            cnt <= {{ADDR_W{1'b0}}, accept};
          end else if (last_accept) begin
            state <= RUN;
            cnt   <= '0;
          end else if (accept) begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
